// File: rtl/mag_countdown_timer_pkg.sv
// ---------------------------------------------------------------------------
// mag_countdown_timer_pkg
//   Shared definitions for the magnetron cook-time countdown timer:
//   FSM state codes, BCD limit constants and a digit validity helper.
// ---------------------------------------------------------------------------
package mag_countdown_timer_pkg;

    // State codes are visible on the debug port, so the encoding is fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // count is 0:00
        ST_ARMED = 2'd1,   // nonzero count, stopped, never run since entry
        ST_RUN   = 2'd2,   // counting down
        ST_PAUSE = 2'd3    // nonzero count, stopped after running
    } mag_state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;

    // True when the nibble is a legal decimal digit.
    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return (d <= BCD_NINE);
    endfunction

endpackage

// File: rtl/mag_bcd_digit.sv
// ---------------------------------------------------------------------------
// mag_bcd_digit
//   One registered BCD digit of the countdown display.
//   Per-cycle priority: clear > decrement > load.
//   Decrementing from 0 wraps to MAX_VAL and raises o_borrow for the next
//   more significant digit.
// Ports
//   clk, resetn      clock, asynchronous active-low reset
//   i_clr            synchronous clear to 0
//   i_load           load i_load_val
//   i_load_val       value to load (4-bit BCD)
//   i_dec            decrement request (borrow in from the less significant digit)
//   o_val            current digit value
//   o_zero           digit is 0
//   o_borrow         a decrement of this digit wraps, so the next digit must decrement
// ---------------------------------------------------------------------------
module mag_bcd_digit #(
    parameter int MAX_VAL = 9
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic [3:0] o_val,
    output logic       o_zero,
    output logic       o_borrow
);

    localparam logic [3:0] MAX_BCD = 4'(MAX_VAL);

    logic [3:0] r_val;
    logic [3:0] w_val_nxt;

    assign o_val    = r_val;
    assign o_zero   = (r_val == 4'd0);
    assign o_borrow = i_dec & (r_val == 4'd0);

    // Next digit value: clear, decrement with wrap, load, or hold.
    always_comb begin
        w_val_nxt = r_val;
        if (i_clr) begin
            w_val_nxt = 4'd0;
        end else if (i_dec) begin
            if (r_val == 4'd0) begin
                w_val_nxt = MAX_BCD;
            end else begin
                w_val_nxt = r_val - 4'd1;
            end
        end else if (i_load) begin
            w_val_nxt = i_load_val;
        end else begin
            w_val_nxt = r_val;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_val <= 4'd0;
        end else begin
            r_val <= w_val_nxt;
        end
    end

endmodule

// File: rtl/mag_countdown_timer.sv
// ---------------------------------------------------------------------------
// mag_countdown_timer
//   Cook-time countdown timer for the magnetron controller. Digits are keyed
//   in while stopped, the M:SS count decrements once per TICK_DIV clocks
//   while running, and timer_done / done_pulse report reaching 0:00.
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   clearn       synchronous active-low clear (keypad CLEAR)
//   digit_valid  one-cycle keypad digit strobe
//   digit        keypad BCD digit
//   mag_on       magnetron running; enables counting
//   min_bcd      minutes digit
//   sec_tens     seconds tens digit
//   sec_ones     seconds ones digit
//   timer_done   registered level, count is 0:00
//   done_pulse   one-cycle pulse when a decrement reaches 0:00
//   state        FSM state code
// ---------------------------------------------------------------------------
module mag_countdown_timer
    import mag_countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse,
    output logic [1:0] state
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

    mag_state_t     r_state, w_state_nxt;
    logic [PW-1:0]  r_presc, w_presc_nxt;
    logic           r_timer_done, w_timer_done_nxt;
    logic           r_done_pulse, w_done_pulse_nxt;

    logic [3:0]     w_min, w_tens, w_ones;
    logic           w_min_zero, w_tens_zero, w_ones_zero;
    logic           w_ones_borrow, w_tens_borrow, w_min_borrow;
    logic           w_count_zero, w_tick, w_dec, w_clr;
    logic           w_accept, w_entry_zero, w_last_sec;

    assign w_count_zero = w_min_zero & w_tens_zero & w_ones_zero;
    assign w_tick       = (r_state == ST_RUN) && (r_presc == TICK_LAST);
    // Clear wins over a decrement; a zero count is never decremented.
    assign w_dec        = w_tick & ~w_count_zero & clearn;
    // A borrow out of the minutes digit would mean 0:00 underflow; it cannot
    // occur because w_dec is gated, but if it ever did, fail safe to 0:00.
    assign w_clr        = ~clearn | w_min_borrow;

    // Entry is refused for non-decimal digits and when the current ones digit
    // would become a seconds-tens digit above 5.
    assign w_accept     = clearn & digit_valid & ~mag_on & (r_state != ST_RUN)
                        & bcd_digit_ok(digit) & (w_ones <= BCD_FIVE);
    assign w_entry_zero = (w_tens == 4'd0) && (w_ones == 4'd0) && (digit == 4'd0);
    assign w_last_sec   = w_min_zero & w_tens_zero & (w_ones == 4'd1);

    // Digit chain: ones shift in the keypad digit, borrows ripple upward.
    mag_bcd_digit #(.MAX_VAL(9)) u_ones (
        .clk(clk), .resetn(resetn), .i_clr(w_clr), .i_load(w_accept),
        .i_load_val(digit), .i_dec(w_dec),
        .o_val(w_ones), .o_zero(w_ones_zero), .o_borrow(w_ones_borrow)
    );
    mag_bcd_digit #(.MAX_VAL(5)) u_tens (
        .clk(clk), .resetn(resetn), .i_clr(w_clr), .i_load(w_accept),
        .i_load_val(w_ones), .i_dec(w_ones_borrow),
        .o_val(w_tens), .o_zero(w_tens_zero), .o_borrow(w_tens_borrow)
    );
    mag_bcd_digit #(.MAX_VAL(9)) u_min (
        .clk(clk), .resetn(resetn), .i_clr(w_clr), .i_load(w_accept),
        .i_load_val(w_tens), .i_dec(w_tens_borrow),
        .o_val(w_min), .o_zero(w_min_zero), .o_borrow(w_min_borrow)
    );

    // FSM next state, prescaler, and next values of the status outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_presc_nxt      = {PW{1'b0}};
        w_done_pulse_nxt = 1'b0;
        w_timer_done_nxt = w_count_zero;
        if (w_clr) begin
            w_state_nxt      = ST_IDLE;
            w_timer_done_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_entry_zero) begin
                        w_state_nxt = ST_ARMED;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ARMED, ST_PAUSE: begin
                    // Keying 0 onto e.g. 1:00 leaves 0:00, which is IDLE.
                    if (w_accept) begin
                        w_state_nxt = w_entry_zero ? ST_IDLE : r_state;
                    end else if (mag_on && !w_count_zero) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_RUN: begin
                    if (w_dec && w_last_sec) begin
                        w_state_nxt      = ST_IDLE;
                        w_done_pulse_nxt = 1'b1;
                    end else if (!mag_on) begin
                        w_state_nxt = ST_PAUSE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_presc_nxt = w_tick ? {PW{1'b0}} : (r_presc + PW'(1));
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
            // timer_done tracks the digits that are loaded on this same edge.
            if (w_dec) begin
                w_timer_done_nxt = w_last_sec;
            end else if (w_accept) begin
                w_timer_done_nxt = w_entry_zero;
            end else begin
                w_timer_done_nxt = w_count_zero;
            end
        end
    end

    // State, prescaler and status output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_presc      <= {PW{1'b0}};
            r_timer_done <= 1'b1;
            r_done_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_timer_done <= w_timer_done_nxt;
            r_done_pulse <= w_done_pulse_nxt;
        end
    end

    assign min_bcd    = w_min;
    assign sec_tens   = w_tens;
    assign sec_ones   = w_ones;
    assign timer_done = r_timer_done;
    assign done_pulse = r_done_pulse;
    assign state      = r_state;

endmodule

// File: tb/tb_mag_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_mag_countdown_timer
//   Self-checking bench for mag_countdown_timer with TICK_DIV=4. A reference
//   model keeps the count as whole seconds and the state as an integer code;
//   every clock all outputs are compared against it, with additional fixed
//   checks on the directed scenarios followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_mag_countdown_timer;

    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       resetn, clearn, digit_valid, mag_on;
    logic [3:0] digit;
    logic [3:0] min_bcd, sec_tens, sec_ones;
    logic       timer_done, done_pulse;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: count in seconds, state code, cycles spent running.
    int   m_secs;
    int   m_state;
    int   m_presc;
    logic m_pulse;

    mag_countdown_timer #(.TICK_DIV(TICK)) dut (
        .clk(clk), .resetn(resetn), .clearn(clearn),
        .digit_valid(digit_valid), .digit(digit), .mag_on(mag_on),
        .min_bcd(min_bcd), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .timer_done(timer_done), .done_pulse(done_pulse), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] disp_now();
        return {4'h0, min_bcd, sec_tens, sec_ones};
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_state = 0;
        m_presc = 0;
        m_pulse = 1'b0;
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        int  s;
        int  tens;
        int  ones;
        bit  acc;
        s    = m_state;
        tens = (m_secs % 60) / 10;
        ones = m_secs % 10;
        m_pulse = 1'b0;
        if (!clearn) begin
            model_reset();
        end else if (s == 2) begin
            m_presc++;
            if (m_presc == TICK) begin
                m_presc = 0;
                m_secs--;
                if (m_secs == 0) begin
                    m_state = 0;
                    m_pulse = 1'b1;
                end
            end
            if (m_state == 2 && !mag_on) m_state = 3;
        end else begin
            acc = digit_valid && !mag_on && (int'(digit) <= 9) && (ones <= 5);
            if (acc) m_secs = tens * 60 + ones * 10 + int'(digit);
            if (m_secs == 0)      m_state = 0;
            else if (acc)         m_state = (s == 0) ? 1 : s;
            else if (mag_on)      m_state = 2;
        end
        if (m_state != 2) m_presc = 0;
    endtask

    task automatic check_all();
        logic [3:0] em, et, eo;
        em = 4'(m_secs / 60);
        et = 4'((m_secs % 60) / 10);
        eo = 4'(m_secs % 10);
        check_eq("display",    disp_now(), {4'h0, em, et, eo});
        check_eq("timer_done", 16'(timer_done), 16'(m_secs == 0));
        check_eq("done_pulse", 16'(done_pulse), 16'(m_pulse));
        check_eq("state",      16'(state), 16'(m_state));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        clearn = 1'b0;
        step();
        check_eq("clr_disp", disp_now(), 16'h0000);
        check_eq("clr_done", 16'(timer_done), 16'd1);
        check_eq("clr_pulse", 16'(done_pulse), 16'd0);
        clearn = 1'b1;
    endtask

    // Reset pulsed between edges: outputs must change with no clock edge.
    task automatic async_reset_pulse();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        check_eq("arst_disp", disp_now(), 16'h0000);
        check_eq("arst_done", 16'(timer_done), 16'd1);
        check_eq("arst_state", 16'(state), 16'd0);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1; clearn = 1'b1; digit_valid = 1'b0; digit = 4'd0; mag_on = 1'b0;
        model_reset();

        // Reset with no clock edge
        #1 resetn = 1'b0;
        #1;
        check_all();
        check_eq("rst_done", 16'(timer_done), 16'd1);
        #1 resetn = 1'b1;

        // Entry and rejection rules
        key(4'd1); key(4'd3); key(4'd0);
        check_eq("entry_130", disp_now(), 16'h0130);
        check_eq("entry_state", 16'(state), 16'd1);
        check_eq("entry_done", 16'(timer_done), 16'd0);
        key(4'hA);
        check_eq("reject_hex", disp_now(), 16'h0130);
        key(4'd7);
        check_eq("entry_307", disp_now(), 16'h0307);
        key(4'd2);
        check_eq("reject_tens", disp_now(), 16'h0307);
        clear_pulse();

        // Borrow 1:00 -> 0:59 -> 0:58
        key(4'd1); key(4'd0); key(4'd0);
        mag_on = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
            check_eq("borrow", disp_now(), (i < 4) ? 16'h0100 : ((i < 8) ? 16'h0059 : 16'h0058));
        end
        mag_on = 1'b0;
        step();
        clear_pulse();

        // Run 0:02 down to done, then hold
        key(4'd2);
        mag_on = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) step();
        check_eq("done_disp", disp_now(), 16'h0000);
        check_eq("done_pulse_hi", 16'(done_pulse), 16'd1);
        check_eq("done_level", 16'(timer_done), 16'd1);
        check_eq("done_state", 16'(state), 16'd0);
        for (int i = 0; i < 20; i++) step();
        check_eq("done_hold", disp_now(), 16'h0000);
        mag_on = 1'b0;
        step();

        // Pause and resume from 0:10
        key(4'd1); key(4'd0);
        mag_on = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) step();
        mag_on = 1'b0;
        step();
        check_eq("pause_disp", disp_now(), 16'h0009);
        check_eq("pause_state", 16'(state), 16'd3);
        for (int i = 0; i < 3; i++) step();
        mag_on = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("resume", disp_now(), (i < 4) ? 16'h0009 : 16'h0008);
        end
        mag_on = 1'b0;
        step();
        clear_pulse();

        // Clear mid-run
        key(4'd5);
        mag_on = 1'b1;
        step(); step(); step();
        clear_pulse();
        check_eq("clr_run_state", 16'(state), 16'd0);
        mag_on = 1'b0;
        step();

        // Asynchronous reset mid-run
        key(4'd5);
        mag_on = 1'b1;
        step(); step();
        async_reset_pulse();
        mag_on = 1'b0;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 900; i++) begin
            clearn      = ($urandom_range(0, 39) != 0);
            digit_valid = ($urandom_range(0, 3) == 0);
            digit       = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 14) == 0) mag_on = ~mag_on;
            if ($urandom_range(0, 299) == 0) async_reset_pulse();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
